regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every write-back payload and RF write port.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count; address width is log2(NUM_REGS) = 5.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 SHALL have ports alu_valid  input  1, alu_rd  input  5, alu_data  input  XLEN: ALU write-back request, destination, value.
REQ-006 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-007 SHALL have ports lsu_valid  input  1, lsu_rd  input  5, lsu_data  input  XLEN: load-unit write-back request.
REQ-008 SHALL have port lsu_ready  output  1  LSU request accepted this cycle.
REQ-009 SHALL have ports issue_valid  input  1, issue_rd  input  5: instruction issued that will write issue_rd.
REQ-010 SHALL have ports rs1_addr, rs2_addr  input  5 each: source registers of the instruction in decode.
REQ-011 SHALL have ports rs1_busy, rs2_busy  output  1 each: source has an outstanding write.
REQ-012 SHALL have ports rf_we  output  1, rf_waddr  output  5, rf_wdata  output  XLEN: drive the register file write port (regWrite, rd, dataIn).

Function
REQ-013 Handshake SHALL complete on a requester when valid and ready are both 1 at a rising edge; a requester holding valid SHALL keep rd/data stable until accepted.
REQ-014 At most one of alu_ready/lsu_ready SHALL be 1 in any cycle; ready SHALL depend combinationally on valid and the priority pointer only.
REQ-015 Single valid requester SHALL be granted in the same cycle (no idle bubble).
REQ-016 Both valid: grant SHALL go to the requester not granted most recently (round-robin); pointer updates only on a completed handshake.
REQ-017 Write latency SHALL be exactly one cycle: on handshake at edge N, rf_we=1 with that rd/data during cycle N+1; rf_* outputs are registered.
REQ-018 Handshake with rd=0 SHALL be accepted but produce rf_we=0 in the following cycle (x0 never written).
REQ-019 Throughput SHALL be one write per cycle with back-to-back handshakes sustaining rf_we=1 continuously.
REQ-020 Scoreboard: 32-bit busy vector; issue_valid with issue_rd!=0 SHALL set busy[issue_rd] at the edge; issue_rd=0 ignored.
REQ-021 busy[rf_waddr] SHALL clear at the edge ending the cycle in which rf_we=1, i.e. the same edge the RF captures the data.
REQ-022 Same register set by issue and cleared by write at the same edge: set SHALL win (newer producer).
REQ-023 rsN_busy SHALL equal busy[rsN_addr], forced to 0 for rsN_addr=0; combinational from state.
REQ-024 Two outstanding producers of one rd SHALL NOT be tracked separately; first write-back clears the bit (issue logic prevents WAW issue while busy).
REQ-025 rf_wdata/rf_waddr when rf_we=0 SHALL hold last written values (no toggling).

Reset
REQ-026 While reset=0: alu_ready=lsu_ready=0, busy vector all 0, rf_we=0, rf_waddr=0, rf_wdata=0, round-robin pointer = "LSU last" so ALU wins the first tie.
REQ-027 Reset asserted mid-operation SHALL discard any pending write (rf_we=0 next cycle) and all busy bits regardless of same-cycle issue/handshake.
REQ-028 First handshake SHALL be possible in the first cycle reset=1 is sampled.

Structure
REQ-029 Shared package rf_ctrl_pkg SHALL hold XLEN, NUM_REGS, REG_ADDR_W=5 and the grant enum {GNT_ALU, GNT_LSU}.
REQ-030 Round-robin grant logic SHALL be one sub-module, wb_rr_arbiter (2 requesters, pointer register, ready outputs); scoreboard and write register remain in the top.

Verification
REQ-031 ALU only, rd=5 data=0xDEADBEEF at edge N -> alu_ready=1 cycle N, rf_we=1/rf_waddr=5/rf_wdata=0xDEADBEEF in cycle N+1, then rf_we=0.
REQ-032 Both valid for 4 cycles after reset (ALU rd=1..4, LSU rd=11..14) -> grants ALU,LSU,ALU,LSU; rf_waddr 1,11,2,12 on consecutive cycles.
REQ-033 issue rd=7, then rs1_addr=7 -> rs1_busy=1 until edge after rf_we with rf_waddr=7; rs1_addr=0 -> rs1_busy=0 always.
REQ-034 issue rd=9 same edge as rf_we for rd=9 -> busy[9]=1 afterwards.
REQ-035 LSU handshake rd=0 data=0x1234 -> lsu_ready=1, rf_we=0 next cycle, no busy change.
REQ-036 Reset=0 one cycle mid-stream with busy bits set and a write pending -> next cycle rf_we=0, rs1_busy=rs2_busy=0 for all addresses, ALU wins next tie.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_ctrl_pkg
// Shared definitions for the register-file write-back path:
//   XLEN       - default write-back payload / RF data width
//   NUM_REGS   - default architectural register count
//   REG_ADDR_W - register address width
//   gnt_e      - identifies which write-back source owns the RF write port
// ---------------------------------------------------------------------------
package rf_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-requester round-robin arbiter for the RF write port.
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous active-low reset
//   i_alu_valid  - ALU write-back request
//   i_lsu_valid  - LSU write-back request
//   o_alu_ready  - ALU granted this cycle (combinational)
//   o_lsu_ready  - LSU granted this cycle (combinational)
// ---------------------------------------------------------------------------
module wb_rr_arbiter
    import rf_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_alu_valid,
    input  logic i_lsu_valid,
    output logic o_alu_ready,
    output logic o_lsu_ready
);

    // r_last remembers who won the most recent handshake; the other side
    // wins the next tie.
    gnt_e r_last;
    gnt_e w_gnt;
    logic w_any;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last <= GNT_LSU;          // ALU wins the first tie after reset
        end else if (w_any) begin
            r_last <= w_gnt;            // any request that is presented is granted
        end
    end

    always_comb begin
        w_any = i_alu_valid | i_lsu_valid;
        w_gnt = GNT_ALU;
        if (i_alu_valid && i_lsu_valid) begin
            w_gnt = (r_last == GNT_LSU) ? GNT_ALU : GNT_LSU;
        end else if (i_lsu_valid) begin
            w_gnt = GNT_LSU;
        end
        o_alu_ready = reset && w_any && (w_gnt == GNT_ALU);
        o_lsu_ready = reset && w_any && (w_gnt == GNT_LSU);
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates ALU and LSU write-backs onto a single registered RF write port
// and keeps a busy scoreboard of registers with outstanding producers.
// Ports:
//   clk, reset                      - clock; synchronous active-low reset
//   alu_valid/alu_rd/alu_data       - ALU write-back request
//   alu_ready                       - ALU request accepted this cycle
//   lsu_valid/lsu_rd/lsu_data       - LSU write-back request
//   lsu_ready                       - LSU request accepted this cycle
//   issue_valid/issue_rd            - issued instruction will write issue_rd
//   rs1_addr/rs2_addr               - decode-stage source registers
//   rs1_busy/rs2_busy               - source has an outstanding write
//   rf_we/rf_waddr/rf_wdata         - registered RF write port
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN     = rf_ctrl_pkg::XLEN,
    parameter int NUM_REGS = rf_ctrl_pkg::NUM_REGS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alu_valid,
    input  logic [rf_ctrl_pkg::REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]                   alu_data,
    output logic                              alu_ready,
    input  logic                              lsu_valid,
    input  logic [rf_ctrl_pkg::REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]                   lsu_data,
    output logic                              lsu_ready,
    input  logic                              issue_valid,
    input  logic [rf_ctrl_pkg::REG_ADDR_W-1:0] issue_rd,
    input  logic [rf_ctrl_pkg::REG_ADDR_W-1:0] rs1_addr,
    input  logic [rf_ctrl_pkg::REG_ADDR_W-1:0] rs2_addr,
    output logic                              rs1_busy,
    output logic                              rs2_busy,
    output logic                              rf_we,
    output logic [rf_ctrl_pkg::REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]                   rf_wdata
);

    import rf_ctrl_pkg::*;

    logic                  w_alu_ready;
    logic                  w_lsu_ready;
    logic                  w_hs;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [XLEN-1:0]       w_data;
    logic [NUM_REGS-1:0]   w_busy_nxt;

    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]       r_wdata;
    logic [NUM_REGS-1:0]   r_busy;

    wb_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_alu_valid (alu_valid),
        .i_lsu_valid (lsu_valid),
        .o_alu_ready (w_alu_ready),
        .o_lsu_ready (w_lsu_ready)
    );

    assign alu_ready = w_alu_ready;
    assign lsu_ready = w_lsu_ready;

    // Winner's payload; ready already implies valid.
    always_comb begin
        w_hs   = w_alu_ready | w_lsu_ready;
        w_rd   = w_lsu_ready ? lsu_rd   : alu_rd;
        w_data = w_lsu_ready ? lsu_data : alu_data;
    end

    // Write register: x0 handshakes are consumed without a write, and the
    // address/data hold their last written values while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_hs && (w_rd != '0);
            if (w_hs && (w_rd != '0)) begin
                r_waddr <= w_rd;
                r_wdata <= w_data;
            end
        end
    end

    // Scoreboard next state: clear the register being written this cycle,
    // then apply a new issue so that a same-edge issue wins over the clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (r_we && (r_waddr == REG_ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (issue_valid && (issue_rd == REG_ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign rs1_busy = (rs1_addr != '0) && r_busy[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && r_busy[rs2_addr];

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ar;
        logic        e_lr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Behavioural reference: a set of busy registers, who won last, and the
    // write that the RF port is presenting this cycle.
    bit          m_busy[32];
    bit          m_last_lsu;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic vec_t mk(int rst, int av, int ard, logic [31:0] adat,
                                int lv, int lrd, logic [31:0] ldat,
                                int iv, int ird, int r1, int r2,
                                int ear, int elr, int ewe, int ewa,
                                logic [31:0] ewd, int eb1, int eb2);
        vec_t v;
        v.rst_n = rst[0]; v.av = av[0]; v.ard = ard[4:0]; v.adat = adat;
        v.lv = lv[0]; v.lrd = lrd[4:0]; v.ldat = ldat;
        v.iv = iv[0]; v.ird = ird[4:0]; v.r1 = r1[4:0]; v.r2 = r2[4:0];
        v.e_ar = ear[0]; v.e_lr = elr[0]; v.e_we = ewe[0]; v.e_wa = ewa[4:0];
        v.e_wd = ewd; v.e_b1 = eb1[0]; v.e_b2 = eb2[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    endtask

    function automatic void model_ready(output bit ar, output bit lr);
        ar = 0; lr = 0;
        if (reset) begin
            if (alu_valid && lsu_valid) begin
                if (m_last_lsu) ar = 1; else lr = 1;
            end else if (alu_valid) ar = 1;
            else if (lsu_valid) lr = 1;
        end
    endfunction

    // State change at the upcoming rising edge, from the inputs now applied.
    task automatic model_edge();
        bit ar, lr;
        logic [4:0]  rd;
        logic [31:0] d;
        model_ready(ar, lr);
        if (!reset) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_last_lsu = 1;
            m_we = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            if (m_we) m_busy[m_waddr] = 0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
            if (ar || lr) begin
                m_last_lsu = lr;
                rd = lr ? lsu_rd : alu_rd;
                d  = lr ? lsu_data : alu_data;
                m_we = (rd != 0);
                if (m_we) begin
                    m_waddr = rd; m_wdata = d;
                end
            end else begin
                m_we = 0;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst_n; alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
        issue_valid = v.iv; issue_rd = v.ird; rs1_addr = v.r1; rs2_addr = v.r2;
    endtask

    initial begin
        bit          ear, elr;
        bit          hold_a, hold_l;
        reset = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        m_last_lsu = 1; m_we = 0; m_waddr = 0; m_wdata = 0;

        //          rst av ard adat         lv lrd ldat         iv ird r1 r2 | ar lr we wa wd           b1 b2
        vecs[0]  = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0,  0, 0, 0, 0, 32'h0,       0, 0);
        vecs[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,       0, 0, 0, 0,  0, 0, 0, 0, 32'h0,       0, 0);
        vecs[2]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,       0, 0, 0, 0,  1, 0, 0, 0, 32'h0,       0, 0);
        vecs[3]  = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0,  0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        vecs[4]  = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0,  0, 0, 0, 5, 32'hDEADBEEF, 0, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0,  0, 0, 0, 5, 32'hDEADBEEF, 0, 0);
        vecs[6]  = mk(1, 1, 1, 32'hA1,       1, 11, 32'hB11,     0, 0, 0, 0,  1, 0, 0, 0, 32'h0,       0, 0);
        vecs[7]  = mk(1, 1, 2, 32'hA2,       1, 11, 32'hB11,     0, 0, 0, 0,  0, 1, 1, 1, 32'hA1,      0, 0);
        vecs[8]  = mk(1, 1, 2, 32'hA2,       1, 12, 32'hB12,     0, 0, 0, 0,  1, 0, 1, 11, 32'hB11,    0, 0);
        vecs[9]  = mk(1, 1, 3, 32'hA3,       1, 12, 32'hB12,     0, 0, 0, 0,  0, 1, 1, 2, 32'hA2,      0, 0);
        vecs[10] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0,  0, 0, 1, 12, 32'hB12,    0, 0);
        vecs[11] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0,  0, 0, 0, 12, 32'hB12,    0, 0);
        vecs[12] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       1, 7, 7, 0,  0, 0, 0, 12, 32'hB12,    0, 0);
        vecs[13] = mk(1, 1, 7, 32'h77,       0, 0,  32'h0,       0, 0, 7, 0,  1, 0, 0, 12, 32'hB12,    1, 0);
        vecs[14] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 7, 0,  0, 0, 1, 7, 32'h77,      1, 0);
        vecs[15] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 7, 0,  0, 0, 0, 7, 32'h77,      0, 0);
        vecs[16] = mk(1, 1, 9, 32'h99,       0, 0,  32'h0,       0, 0, 9, 0,  1, 0, 0, 7, 32'h77,      0, 0);
        vecs[17] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       1, 9, 9, 0,  0, 0, 1, 9, 32'h99,      0, 0);
        vecs[18] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 9, 0,  0, 0, 0, 9, 32'h99,      1, 0);
        vecs[19] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 9,  0, 0, 0, 9, 32'h99,      0, 1);
        vecs[20] = mk(1, 0, 0, 32'h0,        1, 0,  32'h1234,    0, 0, 0, 9,  0, 1, 0, 9, 32'h99,      0, 1);
        vecs[21] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 9,  0, 0, 0, 9, 32'h99,      0, 1);
        vecs[22] = mk(1, 1, 4, 32'h44,       0, 0,  32'h0,       1, 3, 9, 0,  1, 0, 0, 9, 32'h99,      1, 0);
        vecs[23] = mk(0, 0, 0, 32'h0,        1, 6,  32'h66,      1, 5, 3, 9,  0, 0, 1, 4, 32'h44,      1, 1);
        vecs[24] = mk(1, 1, 1, 32'h11,       1, 2,  32'h22,      0, 0, 3, 5,  1, 0, 0, 0, 32'h0,       0, 0);
        vecs[25] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 4, 9,  0, 0, 1, 1, 32'h11,      0, 0);
        vecs[26] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 1, 2,  0, 0, 0, 1, 32'h11,      0, 0);

        // Directed vectors with hand-derived expectations.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            cyc = i;
            drive(vecs[i]);
            @(negedge clk);
            chk("alu_ready", {31'd0, alu_ready}, {31'd0, vecs[i].e_ar});
            chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, vecs[i].e_lr});
            chk("rf_we",     {31'd0, rf_we},     {31'd0, vecs[i].e_we});
            chk("rf_waddr",  {27'd0, rf_waddr},  {27'd0, vecs[i].e_wa});
            chk("rf_wdata",  rf_wdata,           vecs[i].e_wd);
            chk("rs1_busy",  {31'd0, rs1_busy},  {31'd0, vecs[i].e_b1});
            chk("rs2_busy",  {31'd0, rs2_busy},  {31'd0, vecs[i].e_b2});
            model_edge();
        end

        // Random traffic against the reference model; a requester that was
        // not accepted keeps its request unchanged.
        hold_a = 0; hold_l = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            cyc = NV + i;
            reset = ($urandom_range(0, 39) != 0);
            if (!hold_a) begin
                alu_valid = $urandom_range(0, 2) != 0;
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!hold_l) begin
                lsu_valid = $urandom_range(0, 2) != 0;
                lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            issue_valid = $urandom_range(0, 1) != 0;
            issue_rd    = 5'($urandom_range(0, 31));
            rs1_addr    = 5'($urandom_range(0, 31));
            rs2_addr    = ($urandom_range(0, 3) == 0) ? issue_rd : 5'($urandom_range(0, 31));
            @(negedge clk);
            model_ready(ear, elr);
            chk("rnd_alu_ready", {31'd0, alu_ready}, {31'd0, ear});
            chk("rnd_lsu_ready", {31'd0, lsu_ready}, {31'd0, elr});
            chk("rnd_rf_we",     {31'd0, rf_we},     {31'd0, m_we});
            chk("rnd_rf_waddr",  {27'd0, rf_waddr},  {27'd0, m_waddr});
            chk("rnd_rf_wdata",  rf_wdata,           m_wdata);
            chk("rnd_rs1_busy",  {31'd0, rs1_busy},
                {31'd0, (rs1_addr != 0) && m_busy[rs1_addr]});
            chk("rnd_rs2_busy",  {31'd0, rs2_busy},
                {31'd0, (rs2_addr != 0) && m_busy[rs2_addr]});
            hold_a = alu_valid && !ear;
            hold_l = lsu_valid && !elr;
            model_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
